// File: rtl/abcd_sequence_driver.sv
// Drives one a/b/c/d group with the pattern a ##1 b[*B_REPS] ##1 c[*C_REPS], d on the last c.
// Optional macro ERR_INJ_EN adds an inject_err input that suppresses d for the run it starts.
module abcd_sequence_driver #(
    parameter int unsigned B_REPS = 2,
    parameter int unsigned C_REPS = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
`ifdef ERR_INJ_EN
    input  logic             inject_err,
`endif
    output logic             busy,
    output logic             done,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic [CNT_W-1:0] seq_count
);

    localparam int unsigned MAX_REPS = (B_REPS > C_REPS) ? B_REPS : C_REPS;
    localparam int unsigned REP_W    = (MAX_REPS > 1) ? $clog2(MAX_REPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_A,
        S_B,
        S_C
    } state_t;

    localparam logic [REP_W-1:0] B_LAST = REP_W'(B_REPS - 1);
    localparam logic [REP_W-1:0] C_LAST = REP_W'(C_REPS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [REP_W-1:0] rep;
    logic [REP_W-1:0] rep_nxt;
    logic             err_q;
    logic             err_nxt;
    logic             err_req;
    logic             done_nxt;
    logic             a_nxt;
    logic             b_nxt;
    logic             c_nxt;
    logic             d_nxt;

`ifdef ERR_INJ_EN
    assign err_req = inject_err;
`else
    assign err_req = 1'b0;
`endif

    // Next state plus the output levels for the cycle after this edge
    always_comb begin
        state_nxt = state;
        rep_nxt   = rep;
        err_nxt   = err_q;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = S_A;
                    rep_nxt   = '0;
                    err_nxt   = err_req;
                end
            end
            S_A: begin
                state_nxt = S_B;
                rep_nxt   = '0;
            end
            S_B: begin
                if (rep == B_LAST) begin
                    state_nxt = S_C;
                    rep_nxt   = '0;
                end else begin
                    rep_nxt = rep + 1'b1;
                end
            end
            S_C: begin
                if (rep == C_LAST) begin
                    state_nxt = S_IDLE;
                    rep_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    rep_nxt = rep + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                rep_nxt   = '0;
            end
        endcase
        // Abort cancels the run outright: no done, no count
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            rep_nxt   = '0;
            done_nxt  = 1'b0;
        end
        a_nxt = (state_nxt == S_A);
        b_nxt = (state_nxt == S_B);
        c_nxt = (state_nxt == S_C);
        d_nxt = (state_nxt == S_C) && (rep_nxt == C_LAST) && !err_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rep       <= '0;
            err_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            a         <= 1'b0;
            b         <= 1'b0;
            c         <= 1'b0;
            d         <= 1'b0;
            seq_count <= '0;
        end else begin
            state <= state_nxt;
            rep   <= rep_nxt;
            err_q <= err_nxt;
            busy  <= (state_nxt != S_IDLE);
            done  <= done_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            c     <= c_nxt;
            d     <= d_nxt;
            if (done_nxt) begin
                seq_count <= seq_count + CNT_W'(1);
            end
        end
    end

endmodule
